// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage AND-OR-INVERT evaluator (AOI/OAI/AO/OA) behind a valid/ready handshake.
// Define AOI_PIPE_HIT_CNT_EN to build the saturating hit counter; otherwise hit_cnt is tied to 0.
module aoi_pipe #(
  parameter int unsigned TERMS = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TERMS*WIDTH-1:0]   in_data,
  input  logic [1:0]               in_mode,
  input  logic [TERMS-1:0]         in_term_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TERMS-1:0]         out_term,
  output logic                     out_y,
  output logic [15:0]              hit_cnt,
  input  logic                     hit_clr
);

  localparam int unsigned CNT_W = 16;

  // Mode bit 0 set: terms are ORs, combine is AND (OAI/OA).
  // Mode bit 1 clear: final result is inverted (AOI/OAI).
  logic                 s1_valid;
  logic [TERMS-1:0]     s1_term;
  logic [1:0]           s1_mode;
  logic                 s2_valid;

  logic                 s2_adv;
  logic                 in_fire;
  logic [TERMS-1:0]     term_nxt;
  logic                 comb_val;
  logic                 y_nxt;

  assign s2_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Per-term reduction; a disabled term takes the identity of the combine op.
  always_comb begin : term_eval
    term_nxt = '0;
    for (int unsigned k = 0; k < TERMS; k++) begin
      if (!in_term_en[k]) begin
        term_nxt[k] = in_mode[0];
      end else if (in_mode[0]) begin
        term_nxt[k] = |in_data[k*WIDTH +: WIDTH];
      end else begin
        term_nxt[k] = &in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : combine_eval
    comb_val = s1_mode[0] ? (&s1_term) : (|s1_term);
    y_nxt    = s1_mode[1] ? comb_val : ~comb_val;
  end

  always_ff @(posedge clk or posedge rst) begin : stage1_reg
    if (rst) begin
      s1_valid <= 1'b0;
      s1_term  <= '0;
      s1_mode  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_term  <= term_nxt;
      s1_mode  <= in_mode;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output registers only load from a valid stage 1, so they never pick up stale data.
  always_ff @(posedge clk or posedge rst) begin : stage2_reg
    if (rst) begin
      s2_valid <= 1'b0;
      out_term <= '0;
      out_y    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_term <= s1_term;
        out_y    <= y_nxt;
      end
    end
  end

`ifdef AOI_PIPE_HIT_CNT_EN
  logic [CNT_W-1:0] hit_q;

  // Clear wins over increment; increment saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin : hit_counter
    if (rst) begin
      hit_q <= '0;
    end else if (hit_clr) begin
      hit_q <= '0;
    end else if (s2_valid && out_ready && out_y && (hit_q != {CNT_W{1'b1}})) begin
      hit_q <= hit_q + CNT_W'(1);
    end
  end

  assign hit_cnt = hit_q;
`else
  logic unused_hit_clr;
  assign unused_hit_clr = hit_clr;
  assign hit_cnt        = CNT_W'(0);
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
// tb_aoi_pipe: randomized and directed checks of aoi_pipe against a queue-based reference model.
module tb_aoi_pipe;

  localparam int T  = 2;
  localparam int W  = 2;
  localparam int DW = T * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic [T-1:0]  in_term_en;
  logic          out_valid;
  logic          out_ready;
  logic [T-1:0]  out_term;
  logic          out_y;
  logic [15:0]   hit_cnt;
  logic          hit_clr;

  aoi_pipe #(.TERMS(T), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_term_en (in_term_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_term   (out_term),
    .out_y      (out_y),
    .hit_cnt    (hit_cnt),
    .hit_clr    (hit_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight result; stage 1 = behind the output register, 2 = presented on the outputs.
  typedef struct {
    logic [T-1:0] term;
    logic         y;
    int           stage;
  } item_t;

  item_t       pipe_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned hits_exp = 0;
  int          delivered = 0;
  logic        acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Evaluate one beat from the functional definition of the four modes.
  function automatic item_t ref_eval(input logic [DW-1:0] d, input logic [1:0] m,
                                     input logic [T-1:0] en);
    item_t r;
    bit    terms_or;
    bit    invert;
    bit    comb;
    int    ones;
    int    set_terms;
    terms_or  = (m == 2'd1) || (m == 2'd3);
    invert    = (m == 2'd0) || (m == 2'd1);
    set_terms = 0;
    r.term    = '0;
    for (int k = 0; k < T; k++) begin
      ones = 0;
      for (int b = 0; b < W; b++) begin
        if (d[k*W + b]) ones++;
      end
      if (!en[k])        r.term[k] = terms_or;
      else if (terms_or) r.term[k] = (ones > 0);
      else               r.term[k] = (ones == W);
      if (r.term[k]) set_terms++;
    end
    comb    = terms_or ? (set_terms == T) : (set_terms > 0);
    r.y     = invert ? !comb : comb;
    r.stage = 1;
    return r;
  endfunction

  // Drive one cycle, check outputs against the model, then advance the model over the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                      input logic [T-1:0] en, input logic ordy, input logic clr,
                      output logic accepted);
    logic  exp_ov;
    logic  exp_ir;
    logic  xfer;
    logic  s2_free;
    item_t nb;
    item_t f;
    @(negedge clk);
    in_valid   = v;
    in_data    = d;
    in_mode    = m;
    in_term_en = en;
    out_ready  = ordy;
    hit_clr    = clr;
    #1;
    exp_ov = (pipe_q.size() > 0) && (pipe_q[0].stage == 2);
    exp_ir = (pipe_q.size() < 2) || ordy;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    if (exp_ov) begin
      check("out_term", 32'(out_term), 32'(pipe_q[0].term));
      check("out_y", 32'(out_y), 32'(pipe_q[0].y));
    end
    check("hit_cnt", 32'(hit_cnt), 32'(hits_exp));
    accepted = v && exp_ir;
    xfer     = exp_ov && ordy;
    s2_free  = !exp_ov || ordy;
    nb       = ref_eval(d, m, en);
    @(posedge clk);
    if (xfer) begin
`ifdef AOI_PIPE_HIT_CNT_EN
      if (pipe_q[0].y && hits_exp != 32'd65535) hits_exp++;
`endif
      void'(pipe_q.pop_front());
      delivered++;
    end
    if (clr) hits_exp = 0;
    if (pipe_q.size() > 0 && pipe_q[0].stage == 1 && s2_free) begin
      f       = pipe_q[0];
      f.stage = 2;
      pipe_q[0] = f;
    end
    if (accepted) pipe_q.push_back(nb);
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'd0, '0, ordy, 1'b0, acc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_y"}, 32'(out_y), 32'd0);
    check({tag, "_out_term"}, 32'(out_term), 32'd0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] bp_data [4];
    logic [1:0]    bp_mode [4];
    int            idx;
    int            base;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_mode    = '0;
    in_term_en = '0;
    out_ready  = 1'b1;
    hit_clr    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b0;

    // Directed AOI beats from the reference examples.
    step(1'b1, 4'b0011, 2'd0, 2'b11, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0110, 2'd0, 2'b11, 1'b1, 1'b0, acc);
    idle(1'b1, 3);

    // Mode sweep on a fixed pattern, then all terms disabled in every mode.
    for (int m = 0; m < 4; m++) step(1'b1, 4'b1101, 2'(m), 2'b11, 1'b1, 1'b0, acc);
    for (int m = 0; m < 4; m++) step(1'b1, DW'($urandom), 2'(m), 2'b00, 1'b1, 1'b0, acc);
    idle(1'b1, 3);

    // Backpressure: four beats, downstream stalled for five cycles.
    for (int i = 0; i < 4; i++) begin
      bp_data[i] = DW'($urandom);
      bp_mode[i] = 2'($urandom);
    end
    base = delivered;
    idx  = 0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 4) step(1'b1, bp_data[idx], bp_mode[idx], 2'b11, (c >= 5), 1'b0, acc);
      else         step(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, acc);
      if (c == 4) check("bp_accepted_while_stalled", 32'(idx), 32'd2);
      if (acc) idx++;
    end
    idle(1'b1, 2);
    check("bp_delivered", 32'(delivered - base), 32'd4);

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 2'($urandom), T'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), acc);
    end
    idle(1'b1, 3);

    // Reset asserted mid-cycle with two beats in flight.
    step(1'b1, 4'b0110, 2'd0, 2'b11, 1'b0, 1'b0, acc);
    step(1'b1, 4'b0000, 2'd0, 2'b11, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    pipe_q.delete();
    hits_exp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 4);

`ifdef AOI_PIPE_HIT_CNT_EN
    // Three y=1 results (AOI with all terms disabled gives 1).
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 2'd0, 2'b00, 1'b1, 1'b0, acc);
    idle(1'b1, 3);
    @(negedge clk);
    #1;
    check("hit_three", 32'(hit_cnt), 32'd3);
    // Clear coincident with a y=1 handshake.
    step(1'b1, '0, 2'd0, 2'b00, 1'b1, 1'b0, acc);
    idle(1'b1, 1);
    step(1'b0, '0, 2'd0, '0, 1'b1, 1'b1, acc);
    @(negedge clk);
    #1;
    check("hit_clr_priority", 32'(hit_cnt), 32'd0);
    // Saturation.
    for (int i = 0; i < 65540; i++) step(1'b1, '0, 2'd0, 2'b00, 1'b1, 1'b0, acc);
    idle(1'b1, 3);
    @(negedge clk);
    #1;
    check("hit_saturate", 32'(hit_cnt), 32'hFFFF);
`else
    // Counter absent: hits and clears must leave hit_cnt at zero.
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 2'd0, 2'b00, 1'b1, 1'b1, acc);
    idle(1'b1, 3);
    @(negedge clk);
    #1;
    check("hit_cnt_tied", 32'(hit_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
